// File: rtl/soma_serial_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
package soma_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/soma_completo_1bit.sv
// 1-bit full adder built from two half-adder cells and an OR on the carries.
module soma_meio_1bit (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module soma_completo_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  logic s1, c1, c2;

  soma_meio_1bit u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
  soma_meio_1bit u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

  assign carry = c1 | c2;
endmodule

// File: rtl/soma_serial_ctrl.sv
// Bit-serial adder sequencer: one shared full adder, one bit per clock, LSB first,
// with a start/busy/done handshake.
module soma_serial_ctrl
  import soma_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_out_q, carry_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fa_s, fa_c;

  soma_completo_1bit u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .cin   (carry_q),
    .sum   (fa_s),
    .carry (fa_c)
  );

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_sr_d    = sum_sr_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;

    case (state_q)
      ST_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = ST_DONE;
          sum_d       = sum_sr_d;
          carry_out_d = fa_c;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      // Unused encoding 2'd3 falls here and behaves as IDLE.
      default: begin
        if (start) begin
          state_d  = ST_RUN;
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_soma_serial_ctrl.sv
// Directed and random checks of the bit-serial adder controller (WIDTH=8).
module tb_soma_serial_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [WIDTH:0] last_res;

  soma_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One add with single-cycle start; inputs are scrambled after acceptance.
  task automatic do_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input string tag);
    logic [WIDTH:0] exp;
    exp = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (i > 0) @(negedge clk);
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      if (i == 0) start = 1'b1;  // ignored while busy
      if (i == 1) start = 1'b0;
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " done"}, done, (i == WIDTH));
      if (i < WIDTH) chk({tag, " hold"}, {carry_out, sum}, last_res);
    end
    chk({tag, " result"}, {carry_out, sum}, exp);
    @(negedge clk);
    chk({tag, " idle_busy"}, busy, 1'b0);
    chk({tag, " idle_done"}, done, 1'b0);
    chk({tag, " held"}, {carry_out, sum}, exp);
    last_res = exp;
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    last_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst sum", sum, 8'h00);
    chk("rst cout", carry_out, 1'b0);

    do_add(8'h05, 8'h03, 1'b0, "add05_03");
    chk("add05_03 val", {carry_out, sum}, 9'h008);
    do_add(8'hFF, 8'h01, 1'b0, "addFF_01");
    chk("addFF_01 val", {carry_out, sum}, 9'h100);
    do_add(8'hFF, 8'hFF, 1'b1, "addFF_FF_c");
    chk("addFF_FF_c val", {carry_out, sum}, 9'h1FF);
    do_add(8'h00, 8'h00, 1'b1, "add00_c");
    chk("add00_c val", {carry_out, sum}, 9'h001);

    // Start held high: back-to-back ops spaced WIDTH+2 cycles apart.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) begin a = 8'h01; b = 8'h01; end
      if (done) done_cnt++;
      chk("held done_pos", done, (i == 8 || i == 18));
      if (i == 8)  chk("held res1", {carry_out, sum}, 9'h030);
      if (i == 9)  chk("held gap_busy", busy, 1'b0);
      if (i == 10) chk("held rerun", busy, 1'b1);
      if (i == 18) chk("held res2", {carry_out, sum}, 9'h002);
    end
    chk("held done_cnt", done_cnt, 2);
    start = 1'b0;
    @(negedge clk);
    last_res = {carry_out, sum};

    // Reset asserted during the fourth RUN cycle discards the operation.
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst sum", {carry_out, sum}, 9'h000);
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      chk("midrst no_done", {busy, done}, 2'b00);
    end
    last_res = '0;

    for (int v = 0; v < 200; v++)
      do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
